// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared port identifiers, in-flight read tag type and latency bound
//            for the dmem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int MAX_READ_LATENCY = 4;

    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/dmem_tag_pipe.sv
// ============================================================================
// Module   : dmem_tag_pipe
// Purpose  : Fixed-depth shift register of read tags; the tag leaving the last
//            stage lines up with the syncram output word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= tag_i;
        end
    end

    for (genvar i = 1; i < DEPTH; i++) begin : g_stage
        always_ff @(posedge clock) begin
            if (reset) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port arbiter for the single-port dmem syncram, with read-tag
//            tracking so each returned word goes back to its issuing port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0,
    parameter int MAX_WAIT     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];

    logic       last_gnt_q, last_gnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       sel1;
    logic       any_gnt;
    tag_t       tag_in;
    tag_t       tag_out;

    // sel1 picks port 1 when a grant is made; any_gnt decides whether one is made.
    always_comb begin
        sel1 = 1'b0;
        if (req1 && !req0) begin
            sel1 = 1'b1;
        end else if (req0 && req1) begin
            if (FIXED_PRIO != 0) begin
                sel1 = (wait_cnt_q == MAX_WAIT_C);
            end else begin
                sel1 = (last_gnt_q == PORT_CPU);
            end
        end
    end

    assign any_gnt = (req0 || req1) && !reset;
    assign gnt0    = any_gnt && !sel1;
    assign gnt1    = any_gnt && sel1;

    assign address_dmem = gnt1 ? addr1  : addr0;
    assign data         = gnt1 ? wdata1 : wdata0;
    assign wren         = (gnt1 && we1) || (gnt0 && we0);
    assign rdata        = q_dmem;

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt1) begin
            last_gnt_d = PORT_DBG;
        end else if (gnt0) begin
            last_gnt_d = PORT_CPU;
        end
    end

    always_comb begin
        wait_cnt_d = 8'd0;
        if (FIXED_PRIO != 0 && req1 && !gnt1) begin
            wait_cnt_d = (wait_cnt_q < MAX_WAIT_C) ? wait_cnt_q + 8'd1 : wait_cnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt_q <= PORT_DBG;
            wait_cnt_q <= 8'd0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign tag_in.valid = (gnt0 && !we0) || (gnt1 && !we1);
    assign tag_in.port  = gnt1;

    dmem_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clock (clock),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // Reset masks the pipe output in the same cycle so dropped reads never surface.
    assign rvalid0 = tag_out.valid && (tag_out.port == PORT_CPU) && !reset;
    assign rvalid1 = tag_out.valid && (tag_out.port == PORT_DBG) && !reset;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Three arbiter configurations driven in lockstep against a
//            behavioural model, plus literal checks of the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam int NI = 3;
    localparam int LAT [NI] = '{1, 1, 3};
    localparam int FIX [NI] = '{0, 1, 0};
    localparam int MW  [NI] = '{8, 3, 8};

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [11:0] a0, a1;
    logic [31:0] d0, d1;

    logic        gnt0_w [NI];
    logic        gnt1_w [NI];
    logic        rv0_w  [NI];
    logic        rv1_w  [NI];
    logic        wren_w [NI];
    logic [11:0] adr_w  [NI];
    logic [31:0] dat_w  [NI];
    logic [31:0] rd_w   [NI];
    logic [31:0] q_w    [NI];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(1), .FIXED_PRIO(0), .MAX_WAIT(8)) u_rr (
        .clock(clk), .reset(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(a0), .addr1(a1), .wdata0(d0), .wdata1(d1),
        .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .rvalid0(rv0_w[0]), .rvalid1(rv1_w[0]),
        .rdata(rd_w[0]), .address_dmem(adr_w[0]), .data(dat_w[0]), .wren(wren_w[0]),
        .q_dmem(q_w[0]));

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(1), .FIXED_PRIO(1), .MAX_WAIT(3)) u_fix (
        .clock(clk), .reset(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(a0), .addr1(a1), .wdata0(d0), .wdata1(d1),
        .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .rvalid0(rv0_w[1]), .rvalid1(rv1_w[1]),
        .rdata(rd_w[1]), .address_dmem(adr_w[1]), .data(dat_w[1]), .wren(wren_w[1]),
        .q_dmem(q_w[1]));

    dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(3), .FIXED_PRIO(0), .MAX_WAIT(8)) u_lat3 (
        .clock(clk), .reset(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(a0), .addr1(a1), .wdata0(d0), .wdata1(d1),
        .gnt0(gnt0_w[2]), .gnt1(gnt1_w[2]), .rvalid0(rv0_w[2]), .rvalid1(rv1_w[2]),
        .rdata(rd_w[2]), .address_dmem(adr_w[2]), .data(dat_w[2]), .wren(wren_w[2]),
        .q_dmem(q_w[2]));

    // Syncram stand-ins: one per instance, read word delayed by that instance's latency.
    logic [31:0] emem [NI][4096];
    logic [31:0] rp   [NI][4];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (wren_w[k]) emem[k][adr_w[k]] <= dat_w[k];
            rp[k][0] <= emem[k][adr_w[k]];
            for (int j = 1; j < 4; j++) rp[k][j] <= rp[k][j-1];
        end
    end

    assign q_w[0] = rp[0][0];
    assign q_w[1] = rp[1][0];
    assign q_w[2] = rp[2][2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: grant rules, shadow memory, and a due-cycle table of reads.
    int          m_last [NI] = '{1, 1, 1};
    int          m_wait [NI] = '{0, 0, 0};
    logic [31:0] smem   [NI][4096];
    bit          sv     [NI][8];
    bit          sp     [NI][8];
    logic [31:0] sd     [NI][8];

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int          g;
            int          s;
            int          s2;
            bit          ev;
            logic [11:0] ga;
            logic [31:0] gd;
            logic        gw;
            logic [63:0] ea;
            logic [63:0] aa;

            if (rst)                  g = -1;
            else if (req0 && !req1)   g = 0;
            else if (!req0 && req1)   g = 1;
            else if (req0 && req1)    g = (FIX[k] != 0) ? ((m_wait[k] == MW[k]) ? 1 : 0)
                                                        : ((m_last[k] == 0) ? 1 : 0);
            else                      g = -1;

            ga = (g == 1) ? a1 : a0;
            gd = (g == 1) ? d1 : d0;
            gw = (g == 1) ? we1 : ((g == 0) ? we0 : 1'b0);

            ea = {17'd0, (g == 0), (g == 1), gw, ga, gd};
            aa = {17'd0, gnt0_w[k], gnt1_w[k], wren_w[k], adr_w[k], dat_w[k]};
            chk($sformatf("model_grant_mem u%0d", k), aa, ea);

            s  = cyc % 8;
            ev = !rst && sv[k][s];
            ea = {30'd0, ev && !sp[k][s], ev && sp[k][s], ev ? sd[k][s] : 32'h0};
            aa = {30'd0, rv0_w[k], rv1_w[k], ev ? rd_w[k] : 32'h0};
            chk($sformatf("model_rvalid_rdata u%0d", k), aa, ea);
            sv[k][s] = 1'b0;

            if (rst) begin
                for (int j = 0; j < 8; j++) sv[k][j] = 1'b0;
                m_last[k] = 1;
                m_wait[k] = 0;
            end else begin
                if (g >= 0) begin
                    m_last[k] = g;
                    if (gw) begin
                        smem[k][ga] = gd;
                    end else begin
                        s2 = (cyc + LAT[k]) % 8;
                        sv[k][s2] = 1'b1;
                        sp[k][s2] = (g == 1);
                        sd[k][s2] = smem[k][ga];
                    end
                end
                if (FIX[k] != 0 && req1 && g != 1)
                    m_wait[k] = (m_wait[k] < MW[k]) ? m_wait[k] + 1 : MW[k];
                else
                    m_wait[k] = 0;
            end
        end
        cyc++;
    end

    task automatic drv(input logic r,
                       input logic r0, input logic w0, input logic [11:0] x0, input logic [31:0] y0,
                       input logic r1, input logic w1, input logic [11:0] x1, input logic [31:0] y1);
        @(posedge clk);
        #1;
        rst = r;
        req0 = r0; we0 = w0; a0 = x0; d0 = y0;
        req1 = r1; we1 = w1; a1 = x1; d1 = y1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;

        // Requests during reset are never granted.
        drv(1'b1, 1'b1, 1'b1, 12'h010, 32'h5, 1'b1, 1'b0, 12'h0, 32'h0);
        @(negedge clk);
        chk("reset_no_grant", {gnt0_w[0], gnt1_w[0], wren_w[0]}, 3'b000);
        drv(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);

        // Loader preloads through port 1.
        drv(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
        @(negedge clk);
        chk("preload_wren", {gnt1_w[0], wren_w[0], dat_w[0]}, {2'b11, 32'hDEADBEEF});
        drv(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h001, 32'h11111111);
        drv(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h002, 32'h22222222);
        drv(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);

        // Single port 0 read.
        drv(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        @(negedge clk);
        chk("single_read_gnt0", {gnt0_w[0], gnt1_w[0]}, 2'b10);
        idle(1);
        @(negedge clk);
        chk("single_read_rvalid", {rv0_w[0], rv1_w[0], rd_w[0]}, {2'b10, 32'hDEADBEEF});
        idle(4);
        drv(1'b1, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);

        // Both ports read continuously.
        for (int i = 0; i < 8; i++) begin
            drv(1'b0, 1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
            @(negedge clk);
            chk($sformatf("rr_gnt i%0d", i), {gnt0_w[0], gnt1_w[0]},
                {(i % 2 == 0), (i % 2 == 1)});
            chk($sformatf("fixed_gnt i%0d", i), {gnt0_w[1], gnt1_w[1]},
                {(i % 4 != 3), (i % 4 == 3)});
            if (i > 0)
                chk($sformatf("rr_rvalid i%0d", i), {rv0_w[0], rv1_w[0], rd_w[0]},
                    {(i % 2 == 1), (i % 2 == 0), (i % 2 == 1) ? 32'h11111111 : 32'h22222222});
        end
        idle(4);

        // Write from port 1, then read it back on port 0.
        drv(1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, 12'h020, 32'h12345678);
        @(negedge clk);
        chk("raw_write", {wren_w[0], adr_w[0], dat_w[0]}, {1'b1, 12'h020, 32'h12345678});
        drv(1'b0, 1'b1, 1'b0, 12'h020, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        @(negedge clk);
        chk("raw_read_issue", {gnt0_w[0], wren_w[0]}, 2'b10);
        idle(1);
        @(negedge clk);
        chk("raw_read_data", {rv0_w[0], rd_w[0]}, {1'b1, 32'h12345678});
        idle(4);

        // Three reads in flight at latency 3, then reset drops them.
        drv(1'b0, 1'b1, 1'b0, 12'h001, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        drv(1'b0, 1'b1, 1'b0, 12'h002, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        drv(1'b0, 1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0);
        drv(1'b1, 1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
        @(negedge clk);
        chk("lat3_reset_cycle", {gnt0_w[2], gnt1_w[2], rv0_w[2], rv1_w[2]}, 4'b0000);
        drv(1'b0, 1'b1, 1'b0, 12'h001, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
        @(negedge clk);
        chk("lat3_post_reset_gnt", {gnt0_w[2], gnt1_w[2], rv0_w[2], rv1_w[2]}, 4'b1000);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            @(negedge clk);
            chk($sformatf("lat3_dropped i%0d", i), {rv0_w[2], rv1_w[2]}, 2'b00);
        end
        idle(4);

        // Quiet bus.
        for (int i = 0; i < 10; i++) begin
            idle(1);
            @(negedge clk);
            for (int k = 0; k < NI; k++)
                chk($sformatf("idle u%0d i%0d", k, i),
                    {gnt0_w[k], gnt1_w[k], wren_w[k], rv0_w[k], rv1_w[k]}, 5'b00000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
